filter_buffer_pingpong: RTL and testbench
=========================================

Name: filter_buffer_pingpong

Overview:
Responder side of the PE engine's filter-read interface (fb_req/fb_addr → fb_data0..3). A DMA/loader streams filter words into one half of a double-buffered, Tout-banked store while the PE engine reads the other half with fixed 1-cycle latency. Halves swap by handshake, so the next layer or tile of filters loads while the current one is consumed.

Parameters:
FILTER_DW, 72, bits per filter word (K*K weights x 8b for one output channel).
Tout, 4, output-channel banks; one read returns one word per bank.
BUF_AW, 9, read/write address width per bank.
DEPTH, 512, words per bank per half; must satisfy DEPTH <= 2^BUF_AW.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_load_start  in  1  pulse; begin filling the free half
i_load_words  in  BUF_AW+1  words per bank for this fill (q_channel*Tin); range 1..DEPTH
i_w_valid  in  1  loader data valid
o_w_ready  out  1  buffer accepts a beat
i_w_data  in  FILTER_DW  loader data beat
o_load_done  out  1  pulse; fill complete
i_fb_req  in  1  PE read request
i_fb_addr  in  BUF_AW  PE read address
o_fb_data0..o_fb_data3  out  FILTER_DW each  bank 0..3 read data
o_fb_vld  out  1  read data valid
o_fb_err  out  1  pulse; read issued with no ready half, or address out of range
o_rd_avail  out  1  read half holds a complete filter set
i_rd_release  in  1  pulse; PE finished with the read half
o_busy  out  1  writer not idle

Behaviour:
- Reset (async, rst=1): both halves invalid; wr_sel=0, rd_sel=0; writer state W_IDLE. All outputs 0, fb_data 0. Memory contents are not cleared. Reset during a fill discards the partial fill.
- Writer FSM:
  - W_IDLE: on i_load_start, latch len=i_load_words and go to W_FILL if half wr_sel is invalid, else to W_WAIT.
  - i_load_start in any other state is ignored.
  - W_WAIT: o_w_ready=0; enter W_FILL when half wr_sel becomes invalid.
  - W_FILL: o_w_ready=1. An accepted beat (valid&ready) writes bank b, addr a. Counters start at b=0, a=0. b increments each beat; on wrap Tout-1→0, a increments. Beat n therefore lands at bank n%Tout, addr n/Tout.
  - Beat with b=Tout-1 and a=len-1: mark half wr_sel valid with stored len, pulse o_load_done next cycle, toggle wr_sel, return to W_IDLE. Total beats = len*Tout.
- o_busy=1 in W_FILL or W_WAIT.
- Read side:
  - o_rd_avail = valid[rd_sel].
  - i_fb_req at cycle t: o_fb_vld=1 and data from half rd_sel, addr i_fb_addr, at t+1 (registered, 1-cycle latency).
  - If the half is invalid, or addr >= stored len: data=0, o_fb_vld=1, o_fb_err=1 at t+1.
  - With no request, o_fb_vld=0 and data holds its last value.
  - Back-to-back requests are supported every cycle.
- Release: i_rd_release while valid[rd_sel] clears valid[rd_sel] and toggles rd_sel; the next cycle reads the other half. Release while invalid is ignored.
- Simultaneous events:
  - Fill-complete and release in the same cycle, targeting different halves: both apply.
  - Same half (W_WAIT waiting on it): the release frees it; the writer enters W_FILL next cycle.
  - A read in the release cycle still uses the old rd_sel.
- The writer never writes the half selected by rd_sel while it is valid. Read and write go to distinct memories, so there is no bypass path.

Decomposition:
- Shared package/header (controller_params.vh): FILTER_DW, Tout, BUF_AW, FILTER_BUFFER_DEPTH, and writer state encodings W_IDLE/W_FILL/W_WAIT.
- Sub-module fb_bank_ram: single-write, single-read, registered-output RAM of DEPTH x FILTER_DW. Instantiate 2 halves x Tout banks.

Test Plan:
- Basic fill and read: load len=16, 64 beats with data=n. Require o_load_done once, o_rd_avail=1, and read addr=5 returns data0..3 = 20,21,22,23 one cycle later with o_fb_vld=1.
- Back-to-back reads: reads of addr 0..15 over consecutive cycles. Require 16 consecutive vld cycles with correct data and no gaps.
- Ping-pong: fill A (len=4) then fill B (len=8); a third start enters W_WAIT with o_w_ready=0. After i_rd_release, the reader sees B (addr 7 valid) and the writer fills A.
- Errors: read before any fill returns 0 with o_fb_err=1. Read at addr=len=16 gives o_fb_err=1. Release with nothing valid changes no state.
- Backpressure and corner case: i_w_valid toggles 50%; the beat count is still exactly len*Tout. Release and last write beat in the same cycle gives both halves correctly tracked.
- Reset mid-fill: assert rst after 10 beats. Require o_rd_avail=0 and o_busy=0; a new full fill then reads correct data.

Source files
------------

// File: rtl/filter_buffer_pingpong_pkg.sv
// Shared constants and writer state encoding for the double-buffered filter store.
// Imported by the top-level filter buffer.
package filter_buffer_pingpong_pkg;

  localparam int FILTER_DW           = 72;
  localparam int TOUT                = 4;
  localparam int BUF_AW              = 9;
  localparam int FILTER_BUFFER_DEPTH = 512;
  localparam int BANK_W              = $clog2(TOUT);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/filter_buffer_pingpong_bank_ram.sv
// Single-write, single-read RAM with a registered read port.
// The read register holds its value when no read is enabled.
module filter_buffer_pingpong_bank_ram #(
  parameter int DW    = 72,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so this maps onto block RAM;
  // the consumer masks rdata until a valid read has been issued.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/filter_buffer_pingpong.sv
// Double-buffered, TOUT-banked filter store: a loader fills one half while the
// PE engine reads the other with 1-cycle latency; halves swap by release handshake.
module filter_buffer_pingpong
  import filter_buffer_pingpong_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_start,
  input  logic [BUF_AW:0]      i_load_words,
  input  logic                 i_w_valid,
  output logic                 o_w_ready,
  input  logic [FILTER_DW-1:0] i_w_data,
  output logic                 o_load_done,
  input  logic                 i_fb_req,
  input  logic [BUF_AW-1:0]    i_fb_addr,
  output logic [FILTER_DW-1:0] o_fb_data0,
  output logic [FILTER_DW-1:0] o_fb_data1,
  output logic [FILTER_DW-1:0] o_fb_data2,
  output logic [FILTER_DW-1:0] o_fb_data3,
  output logic                 o_fb_vld,
  output logic                 o_fb_err,
  output logic                 o_rd_avail,
  input  logic                 i_rd_release,
  output logic                 o_busy
);

  wr_state_e             state_q, state_d;
  logic [BANK_W-1:0]     bank_q;
  logic [BUF_AW-1:0]     addr_q;
  logic [BUF_AW:0]       len_q;
  logic                  wr_sel_q, rd_sel_q;
  logic [1:0]            valid_q, valid_d;
  logic [1:0][BUF_AW:0]  half_len_q;
  logic                  load_done_q;
  logic                  accept, bank_last, last_beat, release_ok;

  logic                  fb_vld_q, fb_zero_q, fb_half_q, rd_err;
  logic [FILTER_DW-1:0]  ram_q [2][TOUT];

  assign accept     = (state_q == W_FILL) && i_w_valid;
  assign bank_last  = (bank_q == BANK_W'(TOUT - 1));
  assign last_beat  = accept && bank_last && ({1'b0, addr_q} == len_q - (BUF_AW + 1)'(1));
  assign release_ok = i_rd_release && valid_q[rd_sel_q];

  // Release and fill-complete may land together; they never target the same half.
  always_comb begin
    valid_d = valid_q;
    if (release_ok) valid_d[rd_sel_q] = 1'b0;
    if (last_beat)  valid_d[wr_sel_q] = 1'b1;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: if (i_load_start) state_d = valid_q[wr_sel_q] ? W_WAIT : W_FILL;
      // Looking at the post-release valid lets a waiting writer start the cycle after release.
      W_WAIT: if (!valid_d[wr_sel_q]) state_d = W_FILL;
      W_FILL: if (last_beat) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= W_IDLE;
      bank_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      valid_q     <= '0;
      half_len_q  <= '0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      load_done_q <= last_beat;
      if (state_q == W_IDLE && i_load_start) len_q <= i_load_words;
      if (state_q != W_FILL) begin
        bank_q <= '0;
        addr_q <= '0;
      end else if (accept) begin
        if (bank_last) begin
          bank_q <= '0;
          addr_q <= addr_q + BUF_AW'(1);
        end else begin
          bank_q <= bank_q + BANK_W'(1);
        end
      end
      if (last_beat) begin
        half_len_q[wr_sel_q] <= len_q;
        wr_sel_q             <= ~wr_sel_q;
      end
      if (release_ok) rd_sel_q <= ~rd_sel_q;
    end
  end

  assign o_w_ready   = (state_q == W_FILL);
  assign o_busy      = (state_q != W_IDLE);
  assign o_load_done = load_done_q;
  assign o_rd_avail  = valid_q[rd_sel_q];

  // Read side: the request's half and error status are captured alongside the RAM read.
  assign rd_err = !valid_q[rd_sel_q] || ({1'b0, i_fb_addr} >= half_len_q[rd_sel_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_vld_q  <= 1'b0;
      fb_zero_q <= 1'b1;
      fb_half_q <= 1'b0;
    end else begin
      fb_vld_q <= i_fb_req;
      if (i_fb_req) begin
        fb_zero_q <= rd_err;
        fb_half_q <= rd_sel_q;
      end
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar b = 0; b < TOUT; b++) begin : g_bank
      filter_buffer_pingpong_bank_ram #(
        .DW    (FILTER_DW),
        .AW    (BUF_AW),
        .DEPTH (FILTER_BUFFER_DEPTH)
      ) u_ram (
        .clk   (clk),
        .we    (accept && (wr_sel_q == 1'(h)) && (bank_q == BANK_W'(b))),
        .waddr (addr_q),
        .wdata (i_w_data),
        .re    (i_fb_req && (rd_sel_q == 1'(h))),
        .raddr (i_fb_addr),
        .rdata (ram_q[h][b])
      );
    end
  end

  assign o_fb_vld   = fb_vld_q;
  assign o_fb_err   = fb_vld_q && fb_zero_q;
  assign o_fb_data0 = fb_zero_q ? '0 : ram_q[fb_half_q][0];
  assign o_fb_data1 = fb_zero_q ? '0 : ram_q[fb_half_q][1];
  assign o_fb_data2 = fb_zero_q ? '0 : ram_q[fb_half_q][2];
  assign o_fb_data3 = fb_zero_q ? '0 : ram_q[fb_half_q][3];

endmodule

// File: tb/tb_filter_buffer_pingpong.sv
// Scoreboard bench for filter_buffer_pingpong: a reference model of both halves
// predicts every read response, which a monitor compares when the DUT answers.
module tb_filter_buffer_pingpong;
  import filter_buffer_pingpong_pkg::*;

  localparam int CW = 300;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_load_start;
  logic [BUF_AW:0]      i_load_words;
  logic                 i_w_valid;
  logic                 o_w_ready;
  logic [FILTER_DW-1:0] i_w_data;
  logic                 o_load_done;
  logic                 i_fb_req;
  logic [BUF_AW-1:0]    i_fb_addr;
  logic [FILTER_DW-1:0] o_fb_data0, o_fb_data1, o_fb_data2, o_fb_data3;
  logic                 o_fb_vld, o_fb_err, o_rd_avail, i_rd_release, o_busy;

  always #5 clk = ~clk;

  filter_buffer_pingpong dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_start (i_load_start),
    .i_load_words (i_load_words),
    .i_w_valid    (i_w_valid),
    .o_w_ready    (o_w_ready),
    .i_w_data     (i_w_data),
    .o_load_done  (o_load_done),
    .i_fb_req     (i_fb_req),
    .i_fb_addr    (i_fb_addr),
    .o_fb_data0   (o_fb_data0),
    .o_fb_data1   (o_fb_data1),
    .o_fb_data2   (o_fb_data2),
    .o_fb_data3   (o_fb_data3),
    .o_fb_vld     (o_fb_vld),
    .o_fb_err     (o_fb_err),
    .o_rd_avail   (o_rd_avail),
    .i_rd_release (i_rd_release),
    .o_busy       (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [FILTER_DW-1:0] mdl [2][TOUT][FILTER_BUFFER_DEPTH];
  bit m_valid [2];
  int m_len   [2];
  bit m_wr_sel, m_rd_sel;
  int exp_done = 0;
  int n_done   = 0;
  int cyc      = 0;

  typedef struct {
    int                     due;
    logic [4*FILTER_DW-1:0] data;
    logic                   err;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_load_done) n_done++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        check("fb_vld", CW'(o_fb_vld), CW'(1));
        check("fb_data", CW'({o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}), CW'(e.data));
        check("fb_err", CW'(o_fb_err), CW'(e.err));
      end else if (o_fb_vld) begin
        check("spurious_vld", CW'(o_fb_vld), CW'(0));
      end
    end
  end

  task automatic model_release();
    if (m_valid[m_rd_sel]) begin
      m_valid[m_rd_sel] = 1'b0;
      m_rd_sel          = ~m_rd_sel;
    end
  endtask

  task automatic push_read(input int addr);
    exp_t e;
    e.due = cyc + 1;
    if (!m_valid[m_rd_sel] || addr >= m_len[m_rd_sel]) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      for (int b = 0; b < TOUT; b++) e.data[b*FILTER_DW +: FILTER_DW] = mdl[m_rd_sel][b][addr];
      e.err = 1'b0;
    end
    sbq.push_back(e);
  endtask

  task automatic drive_cycle(input bit req, input int addr, input bit rel);
    @(negedge clk);
    i_load_start = 1'b0;
    i_w_valid    = 1'b0;
    i_fb_req     = req;
    i_fb_addr    = BUF_AW'(addr);
    i_rd_release = rel;
    if (req) push_read(addr);
    if (rel) model_release();
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 0, 1'b0);
  endtask

  task automatic start_load(input int len);
    @(negedge clk);
    i_fb_req     = 1'b0;
    i_rd_release = 1'b0;
    i_load_start = 1'b1;
    i_load_words = (BUF_AW + 1)'(len);
    @(negedge clk);
    i_load_start = 1'b0;
  endtask

  // Streams up to max_beats beats; bp toggles valid randomly, rel_last releases on the last beat.
  task automatic stream(input int len, input logic [FILTER_DW-1:0] base, input bit bp,
                        input bit rel_last, input int max_beats);
    int total, beats, guard;
    bit full;
    total = len * TOUT;
    if (max_beats < total) total = max_beats;
    full  = (total == len * TOUT);
    beats = 0;
    guard = 0;
    while (beats < total && guard < 4000) begin
      @(negedge clk);
      guard++;
      i_rd_release = 1'b0;
      i_w_valid    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_w_data     = base + FILTER_DW'(beats);
      if (rel_last && beats == total - 1 && o_w_ready) begin
        i_w_valid    = 1'b1;
        i_rd_release = 1'b1;
        model_release();
      end
      if (i_w_valid && o_w_ready) begin
        mdl[m_wr_sel][beats % TOUT][beats / TOUT] = i_w_data;
        beats++;
      end
    end
    @(negedge clk);
    i_w_valid    = 1'b0;
    i_rd_release = 1'b0;
    if (beats < total) check("fill_timeout", CW'(beats), CW'(total));
    if (full && beats == total) begin
      check("busy_after_fill", CW'(o_busy), CW'(0));
      check("ready_after_fill", CW'(o_w_ready), CW'(0));
      m_valid[m_wr_sel] = 1'b1;
      m_len[m_wr_sel]   = len;
      m_wr_sel          = ~m_wr_sel;
      exp_done++;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_load_start = 1'b0; i_load_words = '0; i_w_valid = 1'b0; i_w_data = '0;
    i_fb_req = 1'b0; i_fb_addr = '0; i_rd_release = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_len[0] = 0; m_len[1] = 0;
    m_wr_sel = 1'b0; m_rd_sel = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_avail", CW'(o_rd_avail), CW'(0));
    check("rst_busy", CW'(o_busy), CW'(0));
    check("rst_ready", CW'(o_w_ready), CW'(0));
    check("rst_vld", CW'(o_fb_vld), CW'(0));
    check("rst_data", CW'({o_fb_data3, o_fb_data2, o_fb_data1, o_fb_data0}), CW'(0));
    rst = 1'b0;

    // Read before any fill, then a release with nothing valid
    drive_cycle(1'b1, 0, 1'b0);
    drive_cycle(1'b0, 0, 1'b1);
    idle(2);
    check("rel_empty_avail", CW'(o_rd_avail), CW'(0));

    // Basic fill len=16, data=n
    start_load(16);
    stream(16, '0, 1'b0, 1'b0, 1 << 30);
    idle(1);
    check("done_cnt_a", CW'(n_done), CW'(exp_done));
    check("avail_a", CW'(o_rd_avail), CW'(1));
    drive_cycle(1'b1, 5, 1'b0);
    idle(1);
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, a, 1'b0);
    drive_cycle(1'b1, 16, 1'b0);
    idle(2);

    // Ping-pong: release, fill A (len 4), fill B (len 8), third start waits
    drive_cycle(1'b0, 0, 1'b1);
    idle(1);
    check("avail_after_rel", CW'(o_rd_avail), CW'(0));
    start_load(4);
    stream(4, 72'h100, 1'b0, 1'b0, 1 << 30);
    idle(1);
    check("avail_fill_a", CW'(o_rd_avail), CW'(1));
    start_load(8);
    stream(8, 72'h200, 1'b0, 1'b0, 1 << 30);
    idle(1);
    check("done_cnt_ab", CW'(n_done), CW'(exp_done));
    start_load(6);
    check("wait_ready", CW'(o_w_ready), CW'(0));
    check("wait_busy", CW'(o_busy), CW'(1));
    drive_cycle(1'b1, 3, 1'b1);
    drive_cycle(1'b1, 7, 1'b0);
    check("fill_after_rel", CW'(o_w_ready), CW'(1));
    drive_cycle(1'b1, 8, 1'b0);
    idle(1);

    // Backpressured fill whose last beat coincides with a release
    stream(6, 72'h300, 1'b1, 1'b1, 1 << 30);
    idle(1);
    check("done_cnt_c", CW'(n_done), CW'(exp_done));
    check("avail_c", CW'(o_rd_avail), CW'(1));
    drive_cycle(1'b1, 5, 1'b0);
    drive_cycle(1'b1, 6, 1'b0);
    drive_cycle(1'b0, 0, 1'b1);
    idle(1);
    check("avail_none", CW'(o_rd_avail), CW'(0));
    drive_cycle(1'b1, 2, 1'b0);
    idle(2);

    // Reset after 10 beats of a fill
    start_load(16);
    stream(16, 72'h400, 1'b0, 1'b0, 10);
    @(negedge clk);
    rst = 1'b1;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0; m_wr_sel = 1'b0; m_rd_sel = 1'b0;
    @(negedge clk);
    check("midrst_avail", CW'(o_rd_avail), CW'(0));
    check("midrst_busy", CW'(o_busy), CW'(0));
    check("midrst_ready", CW'(o_w_ready), CW'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    start_load(16);
    stream(16, 72'h500, 1'b1, 1'b0, 1 << 30);
    idle(1);
    check("done_cnt_d", CW'(n_done), CW'(exp_done));
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, a, 1'b0);
    idle(3);
    check("sb_drained", CW'(sbq.size()), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
